// File: rtl/mem_pkg.sv
// Shared memory-system constants: port address width, data width, core id width.
package mem_pkg;
  localparam int ADDR_W = 15;
  localparam int DATA_W = 16;
  localparam int ID_W   = 1;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ID_W-1:0]   core_id_t;
endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter. The pointer remembers the last core that
// actually used a grant; 'take' lets the caller veto a candidate grant so the
// pointer does not advance on a withheld grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       take,
  output logic [1:0] grant
);
  logic last;

  // Candidate grant: a lone requester wins, on contention the core not served last wins
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // Pointer reset to core 1 so core 0 wins the first contention
  always_ff @(posedge clk) begin
    if (rst) begin
      last <= 1'b1;
    end else if (take && (grant != 2'b00)) begin
      last <= grant[1];
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// Two-core arbiter in front of a single-read/single-write data memory.
// Read and write ports are arbitrated independently; a write to the address
// being read in the same cycle is held off so the read returns old data.
// Read completions are tracked with a RD_LAT-deep {valid, core id} tag pipe.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int NCORES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NCORES-1:0]        ren,
  input  logic [NCORES*ADDR_W-1:0] raddr,
  input  logic [NCORES-1:0]        wen_in,
  input  logic [NCORES*ADDR_W-1:0] waddr_in,
  input  logic [NCORES*DATA_W-1:0] wdata_in,
  output logic [NCORES-1:0]        r_stall,
  output logic [NCORES-1:0]        w_stall,
  output logic [NCORES-1:0]        rvalid,
  output data_t                    rdata_out,
  output addr_t                    raddr1,
  input  data_t                    rdata1,
  output logic                     wen,
  output addr_t                    waddr,
  output data_t                    wdata
);
  logic [NCORES-1:0] rreq, wreq, rgnt, wcand, wgnt;
  addr_t             rsel_addr, wsel_addr;
  data_t             wsel_data;
  logic              hazard;
  logic [RD_LAT-1:0] vld_p;
  core_id_t          id_p [RD_LAT];

  // Requests are masked during reset so nothing is granted
  assign rreq = rst ? '0 : ren;
  assign wreq = rst ? '0 : wen_in;

  rr_arb2 u_rd_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (rreq),
    .take  (1'b1),
    .grant (rgnt)
  );

  rr_arb2 u_wr_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (wreq),
    .take  (~hazard),
    .grant (wcand)
  );

  // Steer granted core's address/data and resolve the read-after-write hazard
  always_comb begin
    rsel_addr = '0;
    wsel_addr = '0;
    wsel_data = '0;
    if (rgnt[0])      rsel_addr = raddr[ADDR_W-1:0];
    else if (rgnt[1]) rsel_addr = raddr[2*ADDR_W-1:ADDR_W];
    if (wcand[0]) begin
      wsel_addr = waddr_in[ADDR_W-1:0];
      wsel_data = wdata_in[DATA_W-1:0];
    end else if (wcand[1]) begin
      wsel_addr = waddr_in[2*ADDR_W-1:ADDR_W];
      wsel_data = wdata_in[2*DATA_W-1:DATA_W];
    end
    hazard  = (rgnt != '0) && (wcand != '0) && (rsel_addr == wsel_addr);
    wgnt    = hazard ? '0 : wcand;
    raddr1  = rsel_addr;
    wen     = (wgnt != '0);
    waddr   = wen ? wsel_addr : '0;
    wdata   = wen ? wsel_data : '0;
    r_stall = rreq & ~rgnt;
    w_stall = wreq & ~wgnt;
  end

  // ---- stage boundary: read grant -> tag pipeline (valid is control, reset) ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= (rgnt != '0);
      for (int i = 1; i < RD_LAT; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  // Core id travels alongside valid; no reset needed since valid qualifies it
  always_ff @(posedge clk) begin
    id_p[0] <= core_id_t'(rgnt[1]);
    for (int i = 1; i < RD_LAT; i++) id_p[i] <= id_p[i-1];
  end

  // ---- stage boundary: matured tag -> per-core read strobe ----
  always_comb begin
    rvalid = '0;
    if (vld_p[RD_LAT-1] && !rst) rvalid[id_p[RD_LAT-1]] = 1'b1;
  end

  assign rdata_out = rdata1;
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter RD_LAT, default 1, meaning memory read latency in cycles from raddr1 presented to rdata1 valid (legal 1..4).
REQ-002 SHALL have parameter NCORES, fixed 2, meaning number of requesting cores (generalisation not required).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 ren  input  2  per-core data read request.
REQ-006 raddr  input  30  per-core read word address, core i at bits [15i+14:15i].
REQ-007 wen_in  input  2  per-core write request.
REQ-008 waddr_in  input  30  per-core write word address, same packing.
REQ-009 wdata_in  input  32  per-core write data, core i at bits [16i+15:16i].
REQ-010 r_stall  output  2  per-core read not granted this cycle.
REQ-011 w_stall  output  2  per-core write not granted this cycle.
REQ-012 rvalid  output  2  per-core one-cycle strobe: rdata_out holds that core's read data.
REQ-013 rdata_out  output  16  returned read data, driven from rdata1.
REQ-014 raddr1  output  15  to mem data read port.
REQ-015 rdata1  input  16  from mem data read port.
REQ-016 wen  output  1  to mem write enable.
REQ-017 waddr  output  15  to mem write address.
REQ-018 wdata  output  16  to mem write data.

Function
REQ-019 Read port and write port SHALL each be arbitrated independently, at most one grant per port per cycle; grants combinational from current requests and state.
REQ-020 Single requester on a port SHALL be granted in the same cycle.
REQ-021 On contention, each port SHALL grant the core not granted last on that port (round-robin); last-granted pointer updates only on cycles with a grant.
REQ-022 raddr1 SHALL be the granted core's address; 0 when no read grant.
REQ-023 wen SHALL be 1 only with a write grant; waddr/wdata from the granted core, 0 otherwise.
REQ-024 r_stall[i] = ren[i] & ~read_grant[i]; w_stall[i] = wen_in[i] & ~write_grant[i]; requester SHALL hold its request stable while stalled.
REQ-025 Read-after-write hazard: if granted read and candidate write target the same address in one cycle, the write SHALL be withheld (writer stalled) that cycle; read proceeds with old data.
REQ-026 A tag pipeline RD_LAT deep SHALL carry {valid, core id} of each read grant; rvalid[id] SHALL pulse exactly RD_LAT cycles after grant, one bit max.
REQ-027 Back-to-back reads SHALL be supported every cycle (fully pipelined, no bubbles).
REQ-028 Requests SHALL be ignored while rst is high.

Reset
REQ-029 On rst, both last-granted pointers SHALL be set to core 1 (core 0 wins first contention).
REQ-030 On rst, tag pipeline SHALL clear; rvalid=0 the cycle after reset and until new grants mature; in-flight reads are dropped.
REQ-031 While rst is high: r_stall=0, w_stall=0, wen=0, raddr1=0, waddr=0, wdata=0.

Structure
REQ-032 Core-id width, port address width (15) and data width (16) SHALL be constants in a shared package mem_pkg, also used by mem and core.
REQ-033 One sub-module rr_arb2 (2-way round-robin: req[1:0], grant[1:0], pointer state) SHALL be instantiated twice, once per port.
REQ-034 Implementation SHALL be 120-400 lines of RTL, no latches, no async logic.

Verification
REQ-035 Reset, then ren=2'b11 both addr 0x0010/0x0020, RD_LAT=1 -> cycle0 grant core0, r_stall=2'b10; cycle1 grant core1; rvalid=2'b01 at cycle1, 2'b10 at cycle2.
REQ-036 Both cores write continuously for 4 cycles -> wen=1 each cycle, grants alternate 0,1,0,1; each core stalled every other cycle.
REQ-037 Core0 reads 0x0040 while core1 writes 0x0040 value 0xBEEF (mem held 0x1234) -> rdata_out=0x1234 with rvalid[0]; w_stall[1]=1 that cycle; write lands next cycle; later read returns 0xBEEF.
REQ-038 RD_LAT=3, core0 reads every cycle for 5 cycles -> rvalid[0] high cycles 3-7, data in issue order, no stall.
REQ-039 Assert rst with 2 reads in flight -> no rvalid afterwards, pointers restored, next contention grants core 0.
